pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core (F/D, D/E, E/M, M/W).
- Replaces the fixed per-stage registers, which stall by freezing the clock path.
- Carries instruction, PC and a DATA_W payload bundle (ALU result, HI/LO, DM read data, write-address, ...) with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- The skid buffer lets stall (ready) paths be registered and kept off the critical path.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg_if.sv | 31 +++
 rtl/pipe_entry_reg.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers.
// Payload widths are sized here so every stage instance agrees on its bundle layout.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // F/D: pc+4
    localparam int FD_DATA_W = 32;
    // D/E: rs value, rt value, sign-extended immediate, write address
    localparam int DE_DATA_W = 32 + 32 + 32 + 5;
    // E/M: ALU result, rt value, HI, LO, write address
    localparam int EM_DATA_W = 5 + 32 + 32 + 32 + 32;
    // M/W: write address, ALU result, DM read data, HI, LO
    localparam int MW_DATA_W = 5 + 32 + 32 + 32 + 32;

    // Encoded as the number of held beats, so it drives occupancy directly.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
// slave is the stage's view; master is the environment driving it.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128
);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;

    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_instr, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_data, occupancy
    );

    modport master (
        output in_valid, in_instr, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_data, occupancy
    );

endinterface

// File: rtl/pipe_entry_reg.sv
// One loadable {valid, instr, pc, data} beat register; clear forces the bubble value.
// Clear wins over load; data is left untouched by clear.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 128,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       d_instr,
    input  logic [31:0]       d_pc,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [31:0]       q_instr,
    output logic [31:0]       q_pc,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_instr <= NOP_INSTR;
            q_pc    <= PC_RESET;
            q_data  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_instr <= NOP_INSTR;
            q_pc    <= PC_RESET;
        end else if (load) begin
            q_valid <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register, 1-cycle latency, 1 beat/cycle; optional 2-entry skid
// so in_ready comes straight from a flop. Outputs are stable while out_ready is low.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 128,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter bit          SKID     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    pipe_stage_reg_if.slave bus
);

    occ_t state, state_nxt;
    logic in_ready_q;
    logic in_ready, in_fire, out_fire;

    logic              head_valid;
    logic [31:0]       head_instr, head_pc;
    logic [DATA_W-1:0] head_data;
    logic              skid_valid;
    logic [31:0]       skid_instr, skid_pc;
    logic [DATA_W-1:0] skid_data;

    logic head_load, head_from_skid, head_clear;
    logic skid_load, skid_clear;

    assign in_ready = SKID ? in_ready_q : (!head_valid || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = head_valid && bus.out_ready;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            // Incoming beat is dropped; a same-cycle out_fire was already taken downstream.
            state_nxt  = OCC_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = OCC_ONE;
                        head_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire && SKID) begin
                        state_nxt = OCC_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt  = OCC_EMPTY;
                        head_clear = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (out_fire) begin
                        state_nxt      = OCC_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = OCC_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != OCC_TWO);
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_RESET (PC_RESET)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (head_load),
        .clear   (head_clear),
        .d_instr (head_from_skid ? skid_instr : bus.in_instr),
        .d_pc    (head_from_skid ? skid_pc    : bus.in_pc),
        .d_data  (head_from_skid ? skid_data  : bus.in_data),
        .q_valid (head_valid),
        .q_instr (head_instr),
        .q_pc    (head_pc),
        .q_data  (head_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(
                .DATA_W   (DATA_W),
                .PC_RESET (PC_RESET)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_instr (bus.in_instr),
                .d_pc    (bus.in_pc),
                .d_data  (bus.in_data),
                .q_valid (skid_valid),
                .q_instr (skid_instr),
                .q_pc    (skid_pc),
                .q_data  (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid_ctrl;
            assign unused_skid_ctrl = skid_load | skid_clear | skid_valid;
            assign skid_valid = 1'b0;
            assign skid_instr = NOP_INSTR;
            assign skid_pc    = PC_RESET;
            assign skid_data  = '0;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = head_instr;
    assign bus.out_pc    = head_pc;
    assign bus.out_data  = head_data;
    assign bus.occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with identical stimulus and checks both
// against a queue-based model of the stage's beat ordering and handshake rules.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush;
    logic          iv, ordy;
    logic [31:0]   iins, ipc;
    logic [DW-1:0] idat;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.DATA_W(DW)) b1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) b0 ();

    assign b1.in_valid  = iv;
    assign b1.in_instr  = iins;
    assign b1.in_pc     = ipc;
    assign b1.in_data   = idat;
    assign b1.out_ready = ordy;
    assign b0.in_valid  = iv;
    assign b0.in_instr  = iins;
    assign b0.in_pc     = ipc;
    assign b0.in_data   = idat;
    assign b0.out_ready = ordy;

    pipe_stage_reg #(.DATA_W(DW), .PC_RESET(PC_RESET_DEFAULT), .SKID(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (b1.slave)
    );

    pipe_stage_reg #(.DATA_W(DW), .PC_RESET(PC_RESET_DEFAULT), .SKID(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (b0.slave)
    );

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [DW-1:0] data;
    } beat_t;

    beat_t q1[$];
    beat_t q0[$];
    bit    dc1 = 1'b1;
    bit    dc0 = 1'b1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s1_out_valid", DW'(b1.out_valid), DW'(q1.size() > 0));
        chk("s1_out_instr", DW'(b1.out_instr), DW'(q1.size() > 0 ? q1[0].instr : NOP_INSTR));
        chk("s1_out_pc",    DW'(b1.out_pc),    DW'(q1.size() > 0 ? q1[0].pc : PC_RESET_DEFAULT));
        chk("s1_occupancy", DW'(b1.occupancy), DW'(q1.size()));
        chk("s1_in_ready",  DW'(b1.in_ready),  DW'(q1.size() < 2));
        if (q1.size() > 0)  chk("s1_out_data", b1.out_data, q1[0].data);
        else if (!dc1)      chk("s1_out_data_rst", b1.out_data, '0);

        chk("s0_out_valid", DW'(b0.out_valid), DW'(q0.size() > 0));
        chk("s0_out_instr", DW'(b0.out_instr), DW'(q0.size() > 0 ? q0[0].instr : NOP_INSTR));
        chk("s0_out_pc",    DW'(b0.out_pc),    DW'(q0.size() > 0 ? q0[0].pc : PC_RESET_DEFAULT));
        chk("s0_occupancy", DW'(b0.occupancy), DW'(q0.size()));
        chk("s0_in_ready",  DW'(b0.in_ready),  DW'(q0.size() == 0 || ordy));
        if (q0.size() > 0)  chk("s0_out_data", b0.out_data, q0[0].data);
        else if (!dc0)      chk("s0_out_data_rst", b0.out_data, '0);
    endtask

    // Inputs are already set (at negedge); check, then advance one clock and update the model.
    task automatic step(input bit do_chk);
        bit    rdy1, rdy0, of1, of0;
        beat_t b;
        #1;
        if (do_chk) check_all();
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || ordy;
        of1  = (q1.size() > 0) && ordy;
        of0  = (q0.size() > 0) && ordy;
        b.instr = iins;
        b.pc    = ipc;
        b.data  = idat;
        @(posedge clk);
        if (reset) begin
            q1.delete(); q0.delete();
            dc1 = 1'b0;  dc0 = 1'b0;
        end else if (flush) begin
            q1.delete(); q0.delete();
            dc1 = 1'b1;  dc0 = 1'b1;
        end else begin
            if (of1) void'(q1.pop_front());
            if (iv && rdy1) q1.push_back(b);
            if (q1.size() == 0 && of1) dc1 = 1'b1;
            if (of0) void'(q0.pop_front());
            if (iv && rdy0) q0.push_back(b);
            if (q0.size() == 0 && of0) dc0 = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [31:0] pc);
        ipc  = pc;
        iins = {pc[15:0], 16'h0021} ^ {$urandom_range(255, 1), 24'h0};
        idat = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ordy = 1'b1; iv = 1'b1;
        set_beat(32'h0000_3100);
        step(1'b0);
        step(1'b1);
        reset = 1'b0; iv = 1'b0;
        step(1'b1);
        step(1'b1);

        // streaming at full rate
        iv = 1'b1;
        set_beat(32'h0000_3000); step(1'b1);
        set_beat(32'h0000_3004); step(1'b1);
        set_beat(32'h0000_3008); step(1'b1);
        iv = 1'b0;
        step(1'b1);
        step(1'b1);

        // backpressure fills the skid entry, then drains in order
        ordy = 1'b0; iv = 1'b1;
        set_beat(32'h0000_3000); step(1'b1);
        set_beat(32'h0000_3004); step(1'b1);
        iv = 1'b0;
        step(1'b1);
        step(1'b1);
        ordy = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // flush with two held beats and a beat offered in the same cycle
        ordy = 1'b0; iv = 1'b1;
        set_beat(32'h0000_3020); step(1'b1);
        set_beat(32'h0000_3024); step(1'b1);
        flush = 1'b1;
        set_beat(32'h0000_3010); step(1'b1);
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        step(1'b1);
        step(1'b1);

        // held head blocks SKID=0, then simultaneous pass-through
        ordy = 1'b0; iv = 1'b1;
        set_beat(32'h0000_3030); step(1'b1);
        step(1'b1);
        ordy = 1'b1;
        set_beat(32'h0000_3034); step(1'b1);
        set_beat(32'h0000_3038); step(1'b1);
        iv = 1'b0;
        step(1'b1);
        step(1'b1);

        // reset while full
        ordy = 1'b0; iv = 1'b1;
        set_beat(32'h0000_3040); step(1'b1);
        set_beat(32'h0000_3044); step(1'b1);
        iv = 1'b0; reset = 1'b1;
        step(1'b1);
        reset = 1'b0; ordy = 1'b1;
        step(1'b1);
        step(1'b1);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 500; i++) begin
            iv    = ($urandom_range(3, 0) != 0);
            ordy  = ($urandom_range(2, 0) != 0);
            flush = ($urandom_range(23, 0) == 0);
            reset = ($urandom_range(79, 0) == 0);
            set_beat(32'h0000_3000 + 32'(i * 4));
            step(1'b1);
        end
        iv = 1'b0; flush = 1'b0; reset = 1'b0; ordy = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
